// File: rtl/alu_issue_pkg.sv
// Shared constants, operation-word field positions and FSM state type for the
// ALU issue/writeback stage.
package alu_issue_pkg;

   localparam int DATA_W = 8;
   localparam int OPC_W  = 3;
   localparam int ADDR_W = 3;
   localparam int CC_W   = 4;
   localparam int WORD_W = 16;
   localparam int IMM_W  = 6;

   localparam logic [OPC_W-1:0] OP_CMP = 3'b111;

   localparam int OPC_HI  = 15;
   localparam int OPC_LO  = 13;
   localparam int RD_HI   = 12;
   localparam int RD_LO   = 10;
   localparam int RA_HI   = 9;
   localparam int RA_LO   = 7;
   localparam int IMM_SEL = 6;
   localparam int RB_HI   = 5;
   localparam int RB_LO   = 3;
   localparam int IMM_HI  = 5;
   localparam int IMM_LO  = 0;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
      return {{(DATA_W-IMM_W){1'b0}}, imm};
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Operation-word handshake plus the operand/result bus to the external ALU.
// The slave side is the issue stage; the master side is the surrounding environment.
interface alu_issue_if;
   import alu_issue_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [WORD_W-1:0]   in_op;
   logic [DATA_W-1:0]   alu_a;
   logic [DATA_W-1:0]   alu_b;
   logic [OPC_W-1:0]    alu_n;
   logic [DATA_W-1:0]   alu_r;
   logic [CC_W-1:0]     alu_cc;

   modport master (
      output in_valid, in_op, alu_r, alu_cc,
      input  in_ready, alu_a, alu_b, alu_n
   );

   modport slave (
      input  in_valid, in_op, alu_r, alu_cc,
      output in_ready, alu_a, alu_b, alu_n
   );

endinterface

// File: rtl/alu_issue_regfile.sv
// 8x8 register file: two async operand read ports, one async debug port,
// one synchronous write port; r0 reads as zero and ignores writes.
module alu_issue_regfile
   import alu_issue_pkg::*;
#(
   parameter int NREGS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd
);

   logic [DATA_W-1:0] mem [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (wa != '0)) begin
         mem[wa] <= wd;
      end
   end

   assign ra_data  = (ra_addr  == '0) ? '0 : mem[ra_addr];
   assign rb_data  = (rb_addr  == '0) ? '0 : mem[rb_addr];
   assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Issue and writeback stage around the 8-bit combinational ALU.
// Define ALU_ISSUE_BYPASS_EN for back-to-back issue with alu_r operand forwarding.
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int NREGS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_issue_if.slave        bus,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [CC_W-1:0]   flags,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   state_t            state, state_nxt;
   logic              accept;
   logic              wr_en;
   logic              fwd_a, fwd_b;

   logic [OPC_W-1:0]  opc_p0;
   logic [ADDR_W-1:0] rd_p0, ra_p0, rb_p0;
   logic              imm_sel_p0;
   logic [DATA_W-1:0] imm_p0;
   logic [DATA_W-1:0] ra_data, rb_data;
   logic [DATA_W-1:0] opa_p0, opb_p0;

   logic [ADDR_W-1:0] rd_p1;

   // Decode of the incoming operation word
   assign opc_p0     = bus.in_op[OPC_HI:OPC_LO];
   assign rd_p0      = bus.in_op[RD_HI:RD_LO];
   assign ra_p0      = bus.in_op[RA_HI:RA_LO];
   assign rb_p0      = bus.in_op[RB_HI:RB_LO];
   assign imm_sel_p0 = bus.in_op[IMM_SEL];
   assign imm_p0     = zext_imm(bus.in_op[IMM_HI:IMM_LO]);

   assign accept = bus.in_valid && bus.in_ready;
   assign wr_en  = (state == EXEC) && (bus.alu_n != OP_CMP);

   alu_issue_regfile #(.NREGS(NREGS)) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra_addr  (ra_p0),
      .ra_data  (ra_data),
      .rb_addr  (rb_p0),
      .rb_data  (rb_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .we       (wr_en),
      .wa       (rd_p1),
      .wd       (bus.alu_r)
   );

`ifdef ALU_ISSUE_BYPASS_EN
   // The in-flight result is still on alu_r; its register is written on this same edge
   assign fwd_a = wr_en && (rd_p1 != '0) && (ra_p0 == rd_p1);
   assign fwd_b = wr_en && (rd_p1 != '0) && (rb_p0 == rd_p1);
`else
   assign fwd_a = 1'b0;
   assign fwd_b = 1'b0;
`endif

   assign opa_p0 = fwd_a ? bus.alu_r : ra_data;
   assign opb_p0 = imm_sel_p0 ? imm_p0 : (fwd_b ? bus.alu_r : rb_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Accept in EXEC is only possible with bypass, so one rule covers both builds
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = accept ? EXEC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready = 1'b0;
      if (rst_n) begin
`ifdef ALU_ISSUE_BYPASS_EN
         bus.in_ready = 1'b1;
`else
         bus.in_ready = (state == IDLE);
`endif
      end
   end

   // p0 -> p1: operands and opcode registered into the ALU
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.alu_a <= '0;
         bus.alu_b <= '0;
         bus.alu_n <= '0;
         rd_p1     <= '0;
      end else if (accept) begin
         bus.alu_a <= opa_p0;
         bus.alu_b <= opb_p0;
         bus.alu_n <= opc_p0;
         rd_p1     <= rd_p0;
      end
   end

   // p1 -> writeback: result, destination and condition codes captured
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
         flags    <= '0;
      end else begin
         wb_valid <= wr_en;
         if (wr_en) begin
            wb_addr <= rd_p1;
            wb_data <= bus.alu_r;
         end
         if (state == EXEC) begin
            flags <= bus.alu_cc;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small external ALU model on the interface.
module tb_alu_issue;
   import alu_issue_pkg::*;

   logic              clk;
   logic              rst_n;
   logic              wb_valid;
   logic [2:0]        wb_addr;
   logic [7:0]        wb_data;
   logic [3:0]        flags;
   logic [2:0]        dbg_addr;
   logic [7:0]        dbg_data;

   int n_tests = 0;
   int n_fail  = 0;

   alu_issue_if bus ();

   alu_issue #(.NREGS(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .wb_valid (wb_valid),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .flags    (flags),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // ALU model: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 pass b, 6 pass a, 7 compare (sub)
   // cc = {negative, zero, carry/borrow, 0}
   logic [8:0] sum9;
   logic [7:0] res;
   logic       cy;
   always_comb begin
      sum9 = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      res  = 8'h00;
      cy   = 1'b0;
      case (bus.alu_n)
         3'b000: begin res = sum9[7:0]; cy = sum9[8]; end
         3'b001,
         3'b111: begin res = bus.alu_a - bus.alu_b; cy = (bus.alu_a < bus.alu_b); end
         3'b010: res = bus.alu_a & bus.alu_b;
         3'b011: res = bus.alu_a | bus.alu_b;
         3'b100: res = bus.alu_a ^ bus.alu_b;
         3'b101: res = bus.alu_b;
         default: res = bus.alu_a;
      endcase
      bus.alu_r  = res;
      bus.alu_cc = {res[7], (res == 8'h00), cy, 1'b0};
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
      dbg_addr = a;
      #1;
      chk(tag, {8'h00, dbg_data}, {8'h00, exp});
   endtask

   // Presents op from a negedge, returns 1ns after the accepting edge
   task automatic issue(input logic [15:0] op);
      int guard;
      guard = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      while (!bus.in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.in_ready) chk("accept_timeout", 16'd0, 16'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_op    = 16'hDEAD;
   endtask

   function automatic logic [15:0] op_imm(input logic [2:0] opc, input logic [2:0] rd,
                                          input logic [2:0] ra, input logic [5:0] imm);
      return {opc, rd, ra, 1'b1, imm};
   endfunction

   function automatic logic [15:0] op_reg(input logic [2:0] opc, input logic [2:0] rd,
                                          input logic [2:0] ra, input logic [2:0] rb);
      return {opc, rd, ra, 1'b0, rb, 3'b000};
   endfunction

   initial begin
      int acc;
      int exp_acc;
      int exp_r4;

      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_op    = 16'h0000;
      dbg_addr     = 3'd0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd0);
      chk("rst_wb_valid", {15'd0, wb_valid}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", {15'd0, bus.in_ready}, 16'd1);
      chk("post_rst_flags", {12'd0, flags}, 16'd0);
      chk("post_rst_alu_a", {8'd0, bus.alu_a}, 16'd0);
      for (int a = 0; a < 8; a++) chk_reg("post_rst_reg", a[2:0], 8'h00);

      // r1 <- r0 + 0x2A
      issue(op_imm(3'b000, 3'd1, 3'd0, 6'h2A));
      @(negedge clk);
      chk("add_alu_a", {8'd0, bus.alu_a}, 16'h0000);
      chk("add_alu_b", {8'd0, bus.alu_b}, 16'h002A);
      chk("add_alu_n", {13'd0, bus.alu_n}, 16'd0);
      chk("add_wb_early", {15'd0, wb_valid}, 16'd0);
`ifndef ALU_ISSUE_BYPASS_EN
      chk("exec_ready", {15'd0, bus.in_ready}, 16'd0);
`endif
      @(negedge clk);
      chk("add_wb_valid", {15'd0, wb_valid}, 16'd1);
      chk("add_wb_addr", {13'd0, wb_addr}, 16'd1);
      chk("add_wb_data", {8'd0, wb_data}, 16'h002A);
      chk("add_flags", {12'd0, flags}, 16'h0);
      chk_reg("add_reg1", 3'd1, 8'h2A);
      @(negedge clk);
      chk("add_wb_pulse", {15'd0, wb_valid}, 16'd0);

      // r2 <- r1 + 5 = 0x2F
      issue(op_imm(3'b000, 3'd2, 3'd1, 6'h05));
      repeat (2) @(negedge clk);
      chk("add2_wb_data", {8'd0, wb_data}, 16'h002F);
      chk_reg("add2_reg2", 3'd2, 8'h2F);

      // r3 <- r1 - r2 = 0xFB, N and borrow set
      issue(op_reg(3'b001, 3'd3, 3'd1, 3'd2));
      @(negedge clk);
      chk("sub_alu_b", {8'd0, bus.alu_b}, 16'h002F);
      @(negedge clk);
      chk("sub_wb_data", {8'd0, wb_data}, 16'h00FB);
      chk("sub_flags", {12'd0, flags}, 16'h000A);
      chk_reg("sub_reg3", 3'd3, 8'hFB);

      // Write to r0 pulses but is discarded
      issue(op_imm(3'b000, 3'd0, 3'd1, 6'h01));
      repeat (2) @(negedge clk);
      chk("r0_wb_valid", {15'd0, wb_valid}, 16'd1);
      chk("r0_wb_addr", {13'd0, wb_addr}, 16'd0);
      chk("r0_wb_data", {8'd0, wb_data}, 16'h002B);
      chk_reg("r0_reads_zero", 3'd0, 8'h00);

      // Compare r2 with r2: zero flag only, no register write, no pulse
      issue(op_reg(3'b111, 3'd3, 3'd2, 3'd2));
      repeat (2) @(negedge clk);
      chk("cmp_wb_valid", {15'd0, wb_valid}, 16'd0);
      chk("cmp_flags", {12'd0, flags}, 16'h0004);
      chk_reg("cmp_reg3", 3'd3, 8'hFB);

      // Continuous r4 <- r4 + 1 for 8 edges
      acc = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_op    = op_imm(3'b000, 3'd4, 3'd4, 6'h01);
      for (int i = 0; i < 8; i++) begin
         if (bus.in_ready) acc++;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
`ifdef ALU_ISSUE_BYPASS_EN
      exp_acc = 8;
      exp_r4  = 8;
`else
      exp_acc = 4;
      exp_r4  = 4;
`endif
      chk("stream_accepts", acc[15:0], exp_acc[15:0]);
      chk_reg("stream_reg4", 3'd4, exp_r4[7:0]);

      // r5 <- 0 - 1 dropped by reset while in EXEC
      issue(op_imm(3'b001, 3'd5, 3'd0, 6'h01));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("exec_rst_ready", {15'd0, bus.in_ready}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("exec_rst_wb", {15'd0, wb_valid}, 16'd0);
      chk("exec_rst_flags", {12'd0, flags}, 16'd0);
      chk("exec_rst_idle", {15'd0, bus.in_ready}, 16'd1);
      chk_reg("exec_rst_reg5", 3'd5, 8'h00);
      chk_reg("exec_rst_reg1", 3'd1, 8'h00);
      @(negedge clk);
      chk("exec_rst_no_wb", {15'd0, wb_valid}, 16'd0);
      chk("exec_rst_flags2", {12'd0, flags}, 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue and writeback stage wrapped around the 8-bit combinational ALU. Accepts 16-bit operation words over a valid/ready handshake and reads operands from an 8 × 8-bit register file. Drives registered `a`/`b`/`n` into the ALU, then writes `r` back to the register file and `cc` into a flags register on the next edge. It is the only producer of ALU inputs and the only consumer of ALU outputs.

## Interface
Parameters:
- `NREGS`, default 8: register file depth. Fixed at 8; the 3-bit address fields depend on it.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operation word valid
- `in_ready`  out  1  stage can accept a word
- `in_op`  in  16  operation word
- `alu_a`  out  8  registered ALU operand a
- `alu_b`  out  8  registered ALU operand b
- `alu_n`  out  3  registered ALU opcode
- `alu_r`  in  8  ALU result, combinational from `alu_a`/`alu_b`/`alu_n`
- `alu_cc`  in  4  ALU condition codes, combinational
- `wb_valid`  out  1  one-cycle pulse on writeback
- `wb_addr`  out  3  register written this cycle
- `wb_data`  out  8  value written
- `flags`  out  4  last captured `alu_cc`
- `dbg_addr`  in  3  debug read address
- `dbg_data`  out  8  combinational register file read

## Operation
- Word fields:
  - [15:13] opcode → `alu_n`
  - [12:10] rd
  - [9:7] ra
  - [6] imm_sel
  - [5:3] rb when imm_sel=0
  - [5:0] immediate, zero-extended to 8 bits, when imm_sel=1
  - [2:0] ignored when imm_sel=0
- r0 always reads 0. Writes to r0 are discarded, and `wb_valid` still pulses with `wb_addr`=0.
- Opcode 3'b111 is compare-only: it updates `flags`, does not write the register file, and `wb_valid` stays 0.
- FSM:
  - IDLE: `in_ready`=1. On accept, latch `alu_a`=reg[ra], `alu_b`=reg[rb] or imm, `alu_n`, rd; go to EXEC.
  - EXEC: `in_ready`=0. At the next edge, write reg[rd]←`alu_r` and `flags`←`alu_cc`, pulse `wb_valid`, return to IDLE.
- `alu_a`/`alu_b`/`alu_n` hold their values until the next accept.
- All values are 8-bit unsigned; there is no extension beyond the immediate.

## Timing
- Reset (async assert, sync deassert by clocked logic):
  - FSM → IDLE
  - register file, `alu_a`, `alu_b`, `alu_n`, `flags`, `wb_*` all → 0
  - `in_ready` forced 0 while `rst_n`=0
- Accept at edge T. ALU inputs are valid during cycle T+1. Writeback at edge T+2, with `wb_valid` high during T+2.
- Base throughput: one operation per 2 cycles.
- Handshake: transfer only when `in_valid`&&`in_ready` at an edge. `in_op` may change freely while not accepted.
- Same-cycle writeback and `dbg_addr` read of the same register: `dbg_data` shows the old value. The new value appears the cycle after.
- Reset during EXEC: the in-flight operation is dropped, with no writeback and no flags update.
- Operand read for the next accept occurs in IDLE, after the prior writeback has completed. No hazard exists without bypass.

## Configuration
- `ALU_ISSUE_BYPASS_EN` defined:
  - `in_ready`=1 in EXEC as well, giving back-to-back accepts and one operation per cycle.
  - If an accepting word's ra or rb equals the in-flight rd (rd≠0, in-flight opcode≠3'b111), the operand is taken from `alu_r` instead of the register file.
  - The immediate path is never bypassed.
- Not defined: the 2-cycle FSM above, with `in_ready`=0 in EXEC.

## Structure
- Package `alu_issue_pkg`:
  - opcode width and the `OP_CMP`=3'b111 constant
  - field bit positions
  - FSM state enum (IDLE, EXEC)
- Sub-module `alu_issue_regfile`: 8×8, two async read ports plus a debug read port, one sync write port, r0 hardwired to 0, async reset to 0.
- The FSM, operand mux, bypass and flags logic live in the top level.

## Test plan
- Reset → `in_ready`=0 while `rst_n` low. After release: `in_ready`=1, `flags`=0, `dbg_data`=0 for all addresses.
- Accept {op=000, rd=1, imm_sel=1, imm=6'h2A} at T → `alu_a`=0, `alu_b`=8'h2A in T+1. With the ALU model returning 8'h2A/cc=4'h0, `wb_valid`=1, `wb_addr`=1, `wb_data`=8'h2A at T+2, and reg1=8'h2A afterwards.
- Write to rd=0 → `wb_valid` pulses, `dbg_data`@0 stays 0. Opcode 111 with rd=3 → `flags` updated, reg3 unchanged, `wb_valid`=0.
- Hold `in_valid`=1 continuously → accepts every 2nd cycle without bypass. With `ALU_ISSUE_BYPASS_EN`, accepts every cycle, and `alu_a`=`alu_r` of the previous op when ra = previous rd.
- Assert `rst_n`=0 during EXEC → no writeback pulse, `flags`=0, FSM back in IDLE.
